// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Sequencing controller for a 5-stage RISC-V pipeline. It generates the PC and
// IF/ID load enables and the IF/ID and ID/EX flush requests, and it handles three cases:
//   - load-use stalls,
//   - taken-branch/jump flushes,
//   - the halt drain, which retires older instructions and then freezes the core.
// It also keeps saturating counters of stall cycles and of flush events.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   id_rs1/id_rs2              source register indices of the instruction in ID
//   id_uses_rs1/id_uses_rs2    the ID instruction actually reads that source
//   idex_memread/idex_rd       MemRead bit and destination register in ID/EX
//   idex_halt                  a Halt instruction is in EX
//   ex_redirect                the PC is redirected from EX this cycle
//   pc_write/ifid_write        load enables of the PC and IF/ID
//   ifid_flush/idex_flush      turn IF/ID into a NOP / ID/EX into a bubble at the next edge
//   halted                     the core has drained and is frozen
//   stall_cnt/flush_cnt        saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             idex_halt,
  input  logic             ex_redirect,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DC_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_q;
  logic [DC_W-1:0]  drain_q;
  logic             halted_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use_hz;
  logic freeze;
  logic stall_inc;
  logic flush_inc;

  // Hazard detection and the prioritised pipeline control outputs.
  always_comb begin
    load_use_hz = idex_memread && (idex_rd != 5'd0) &&
                  ((id_uses_rs1 && (id_rs1 == idex_rd)) ||
                   (id_uses_rs2 && (id_rs2 == idex_rd)));
    // A Halt in EX freezes the front end in the same cycle, before the state moves.
    freeze      = (state_q != ST_RUN) || idex_halt;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (!rst_n || freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_redirect) begin
      // The ID instruction is on the wrong path, so any hazard it raises is ignored.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
    end else if (load_use_hz) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end
  end

  // Saturating next values of the performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Run/drain/halted state machine. halted is registered together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      drain_q  <= {DC_W{1'b0}};
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (idex_halt) begin
            state_q <= ST_DRAIN;
            drain_q <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_q == {DC_W{1'b0}}) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_q <= drain_q - DC_W'(1);
          end
        end
        ST_HALTED: begin
          state_q  <= ST_HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          drain_q  <= {DC_W{1'b0}};
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Performance counter registers. Only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. It runs directed scenarios followed by
// randomized traffic. Each cycle the outputs are compared with a reference
// model built from the control priority list. The model tracks the halt as a
// time stamp and the counters as plain integers. Two instances share the same
// inputs: one has 16-bit counters and one has 4-bit counters, so saturation
// can be observed.
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1 = 5'd0, id_rs2 = 5'd0, idex_rd = 5'd0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic        idex_memread = 1'b0, idex_halt = 1'b0, ex_redirect = 1'b0;

  logic        pc_write, ifid_write, ifid_flush, idex_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_halted;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  pipeline_hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .idex_halt(idex_halt),
    .ex_redirect(ex_redirect), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipeline_hazard_ctrl #(.CNT_W(4), .DRAIN_CYCLES(DRAIN)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .idex_halt(idex_halt),
    .ex_redirect(ex_redirect), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state.
  int cyc     = 0;
  int halt_t  = -1;
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit model_hz();
    return idex_memread && (idex_rd != 5'd0) &&
           ((id_uses_rs1 && id_rs1 == idex_rd) || (id_uses_rs2 && id_rs2 == idex_rd));
  endfunction

  function automatic bit model_frozen();
    return (halt_t >= 0) || idex_halt;
  endfunction

  // Expected {pc_write, ifid_write, ifid_flush, idex_flush}.
  function automatic logic [3:0] model_ctrl();
    if (model_frozen())   return 4'b0011;
    else if (ex_redirect) return 4'b1111;
    else if (model_hz())  return 4'b0001;
    else                  return 4'b1100;
  endfunction

  function automatic bit model_halted();
    return (halt_t >= 0) && (cyc >= halt_t + DRAIN + 1);
  endfunction

  // Check the current cycle against the model, then advance by one clock edge.
  task automatic step();
    #2;
    chk("ctrl",     {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {28'd0, model_ctrl()});
    chk("ctrl4",    {28'd0, s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush}, {28'd0, model_ctrl()});
    chk("halted",   {31'd0, halted}, {31'd0, model_halted()});
    chk("halted4",  {31'd0, s_halted}, {31'd0, model_halted()});
    chk("stall",    {16'd0, stall_cnt}, 32'(sat(m_stall, 16)));
    chk("flush",    {16'd0, flush_cnt}, 32'(sat(m_flush, 16)));
    chk("stall4",   {28'd0, s_stall_cnt}, 32'(sat(m_stall, 4)));
    chk("flush4",   {28'd0, s_flush_cnt}, 32'(sat(m_flush, 4)));
    @(posedge clk);
    if (!model_frozen() && ex_redirect) m_flush++;
    else if (!model_frozen() && model_hz()) m_stall++;
    if (halt_t < 0 && idex_halt) halt_t = cyc;
    cyc++;
    #1;
  endtask

  // Reset over one clock edge. Outputs are checked while rst_n is low.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl",   {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, 32'h3);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_stall",  {16'd0, stall_cnt}, 32'd0);
    chk("rst_flush",  {16'd0, flush_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    halt_t  = -1;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    idex_memread = 1'b0; idex_rd = 5'd0; idex_halt = 1'b0; ex_redirect = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd);
    idle();
    idex_memread = 1'b1; idex_rd = rd; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    idle();
    do_reset();

    // Load-use stall on x5.
    load_use(5'd5);
    #1;
    chk("lu_pc",  {31'd0, pc_write}, 32'd0);
    chk("lu_idf", {31'd0, idex_flush}, 32'd1);
    step();
    idle();
    chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);
    // A load to x0 never stalls.
    load_use(5'd0);
    step();
    step();
    chk("lu_x0_cnt", {16'd0, stall_cnt}, 32'd1);

    // A redirect takes priority over a coincident hazard.
    load_use(5'd5);
    ex_redirect = 1'b1;
    step();
    idle();
    chk("rd_flush", {16'd0, flush_cnt}, 32'd1);
    chk("rd_stall", {16'd0, stall_cnt}, 32'd1);
    step();

    // Halt at cycle t together with a redirect.
    idex_halt = 1'b1; ex_redirect = 1'b1;
    step();
    idle();
    chk("h_t1", {31'd0, halted}, 32'd0);
    ex_redirect = 1'b1;
    step();
    chk("h_t2", {31'd0, halted}, 32'd0);
    step();
    chk("h_t3", {31'd0, halted}, 32'd1);
    chk("h_flush", {16'd0, flush_cnt}, 32'd1);
    for (int i = 0; i < 4; i++) step();
    chk("h_hold", {31'd0, halted}, 32'd1);

    // Reset in the middle of DRAIN.
    do_reset();
    idle();
    idex_halt = 1'b1;
    step();
    idle();
    do_reset();
    #1;
    chk("rm_pc", {31'd0, pc_write}, 32'd1);
    step();

    // Saturate the 4-bit stall counter.
    for (int i = 0; i < 20; i++) begin
      load_use(5'd5);
      step();
    end
    idle();
    chk("sat4", {28'd0, s_stall_cnt}, 32'd15);
    chk("sat16", {16'd0, stall_cnt}, 32'd20);
    step();

    // Randomized back-to-back loads, branches, halts and occasional resets.
    for (int i = 0; i < 10000; i++) begin
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_uses_rs1  = 1'($urandom_range(0, 1));
      id_uses_rs2  = 1'($urandom_range(0, 1));
      idex_memread = ($urandom_range(0, 2) != 0);
      idex_rd      = 5'($urandom_range(0, 7));
      ex_redirect  = ($urandom_range(0, 3) == 0);
      idex_halt    = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It drives the write-enable and flush controls of the PC and the IF/ID and ID/EX buffer registers. It implements three functions:
- load-use stall detection;
- taken-branch/jump flush;
- a halt-drain state machine that retires in-flight instructions and then freezes the core.

It sits beside the decode stage and reads decoded register indices from ID and control bits from the ID/EX buffer. It also keeps saturating stall and flush performance counters.

## Interface
- CNT_W, 16, width of each performance counter
- DRAIN_CYCLES, 2, cycles spent in DRAIN after the Halt instruction leaves EX (MEM and WB stages)
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs1  in  5  ReadRegister1 of the instruction in ID
- id_rs2  in  5  ReadRegister2 of the instruction in ID
- id_uses_rs1  in  1  the ID instruction reads rs1
- id_uses_rs2  in  1  the ID instruction reads rs2
- idex_memread  in  1  MemRead bit of the ID/EX register
- idex_rd  in  5  WriteRegister of the ID/EX register
- idex_halt  in  1  Halt bit of the ID/EX register (Halt instruction is in EX)
- ex_redirect  in  1  a branch is taken, or JAL/JALR is in EX (PC redirect this cycle)
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID register load enable
- ifid_flush  out  1  clear IF/ID to a NOP on the next edge
- idex_flush  out  1  clear ID/EX control bits to a bubble on the next edge
- halted  out  1  core is fully halted and all older instructions have retired
- stall_cnt  out  CNT_W  count of load-use stall cycles, saturating
- flush_cnt  out  CNT_W  count of redirect flush events, saturating

## Operation
- State machine states: RUN, DRAIN, HALTED. The state is registered. The stall/flush outputs are combinational from the state and the current inputs.
- RUN transitions:
  - idex_halt=1 → DRAIN, drain counter loaded with DRAIN_CYCLES-1.
  - Otherwise stay in RUN.
- DRAIN: the counter decrements each cycle. At 0 → HALTED.
- HALTED: absorbing state. Only rst_n leaves it.
- Load-use hazard (hz): idex_memread & idex_rd≠0 & ((id_uses_rs1 & id_rs1==idex_rd) | (id_uses_rs2 & id_rs2==idex_rd)).
- Output priority, highest first:
  1. rst_n=0: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1.
  2. HALTED, DRAIN, or (RUN & idex_halt): pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1. Younger instructions are discarded; the Halt itself proceeds.
  3. RUN & ex_redirect: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. A coincident hz is ignored because the ID instruction is wrong-path.
  4. RUN & hz: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1 (bubble inserted).
  5. Else: pc_write=1, ifid_write=1, flushes 0.
- halted=1 exactly when state==HALTED.
- stall_cnt increments on each clock edge where case 4 applied. flush_cnt increments on each edge where case 3 applied. Both saturate at 2^CNT_W-1 with no wrap. Both are cleared only by reset.
- idex_halt with ex_redirect in the same cycle: halt wins (case 2). flush_cnt does not increment.

## Timing
- Stall/flush outputs have zero-cycle latency from their inputs. The effect is on the next rising edge.
- A load-use stall lasts exactly 1 cycle: the load advances to MEM, so hz clears by itself.
- Halt is in EX at cycle t. Outputs force a freeze in cycle t. State is DRAIN during t+1..t+DRAIN_CYCLES. halted=1 from cycle t+DRAIN_CYCLES+1 onward.
- Reset values: state RUN, halted=0, stall_cnt=0, flush_cnt=0, drain counter=0. Control outputs follow priority case 1 while rst_n=0.
- rst_n asserted mid-DRAIN or in HALTED: immediate return to RUN with counters cleared. The first edge after rst_n rises operates normally.
- rst_n deasserts synchronously with respect to clk; this is the system's responsibility.

## Test plan
- Load-use: ID/EX holds lw x5 (idex_memread=1, idex_rd=5); ID holds add reading rs1=5 → one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cnt 0→1. Same with idex_rd=0 → no stall.
- Redirect: ex_redirect=1 with hz=1 in the same cycle → ifid_flush=idex_flush=1, pc_write=1; flush_cnt 0→1; stall_cnt unchanged.
- Halt drain: idex_halt=1 at cycle t with DRAIN_CYCLES=2 → freeze outputs from t; halted=0 at t+1 and t+2; halted=1 at t+3 and held; ex_redirect pulsed at t does not change flush_cnt.
- Reset mid-DRAIN: drop rst_n at t+1 → halted=0, counters 0, state RUN; after release pc_write=1.
- Saturation: CNT_W=4, 20 consecutive load-use hazards → stall_cnt stops at 15.
- Random back-to-back loads and branches checked against a reference model of the priority list for 10k cycles.
